game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5: points needed to win a match (1..15).
REQ-002 Parameter SERVE_TICKS, default 8: tick pulses spent in SERVE before the ball is released (1..255).
REQ-003 Parameter POINT_TICKS, default 4: tick pulses spent in POINT showing the scored point (1..255).
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  raw level from the start button; only a rising edge is a command.
REQ-007 tick  in  1  one-cycle game-speed pulse; all timers count tick pulses, not clk cycles.
REQ-008 miss_p1, miss_p2  in  1 each  ball passed the player-1 or player-2 paddle; sampled only in PLAY.
REQ-009 en_p1, en_p2  out  1 each  paddle enable; low forces the paddle to its start position.
REQ-010 ball_reset  out  1  hold the ball at centre.
REQ-011 ball_run  out  1  ball may move.
REQ-012 serve_dir  out  1  ball launch direction: 0 = toward player 1, 1 = toward player 2.
REQ-013 score_p1, score_p2  out  4 each  unsigned match scores.
REQ-014 winner  out  2  00 none, 01 player 1, 10 player 2; 11 never driven.
REQ-015 state  out  3  current FSM state encoding, for display and debug.

Function
REQ-016 The FSM SHALL have states IDLE=0, SERVE=1, PLAY=2, POINT=3 and OVER=4; codes 5-7 SHALL return to IDLE on the next clk.
REQ-017 A start edge SHALL be detected as start high in this cycle and low in the previous registered sample; holding start high SHALL produce exactly one edge.
REQ-018 In IDLE, a start edge SHALL clear both scores, set winner=00 and enter SERVE on the next clk.
REQ-019 On entry to SERVE the tick counter SHALL load 0; each tick pulse increments it; after SERVE_TICKS pulses the FSM SHALL enter PLAY on the clk following the last pulse.
REQ-020 In PLAY, miss_p1 alone SHALL increment score_p2, set serve_dir=0 (serve toward the player who lost the point) and enter POINT, all on the same clk edge.
REQ-021 In PLAY, miss_p2 alone SHALL increment score_p1, set serve_dir=1 and enter POINT.
REQ-022 In PLAY, miss_p1 and miss_p2 together SHALL score nothing, leave serve_dir unchanged and enter POINT.
REQ-023 POINT SHALL last POINT_TICKS tick pulses; it then SHALL enter OVER if either score equals WIN_SCORE, otherwise SERVE.
REQ-024 On entry to OVER, winner SHALL be set to the player whose score equals WIN_SCORE; a start edge in OVER SHALL clear scores and winner and enter SERVE.
REQ-025 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-026 Start edges in SERVE, PLAY and POINT SHALL be ignored; miss inputs outside PLAY SHALL be ignored.
REQ-027 Outputs by state (en_p1/en_p2, ball_reset, ball_run): IDLE 0,1,0; SERVE 1,1,0; PLAY 1,0,1; POINT 1,1,0; OVER 0,1,0.
REQ-028 All outputs SHALL be registered, or decoded purely from registered state; no input-to-output combinational path.

Reset
REQ-029 While rst_n is low at a clk edge, the block SHALL enter IDLE with scores 0, winner 00, serve_dir 0, counter 0 and the start-edge history 0.
REQ-030 Reset asserted during any state, including mid-countdown, SHALL take effect on that clk edge with no partial score update.

Structure
REQ-031 The state encodings and winner codes SHALL be in the shared package game_pkg.
REQ-032 Tick counting SHALL be a sub-module tick_timer (load, tick, count, done) reused by SERVE and POINT.

Verification
REQ-033 Reset, then start pulse, then 8 ticks: state goes IDLE->SERVE->PLAY, and ball_run=1 exactly on the clk after the 8th tick.
REQ-034 In PLAY, a one-cycle miss_p2 pulse: score_p1=1, serve_dir=1, state=POINT; after 4 ticks, state=SERVE.
REQ-035 miss_p1 and miss_p2 in the same cycle: scores stay 0/0, serve_dir unchanged, POINT then SERVE.
REQ-036 Five miss_p1 points: score_p2=5, state=OVER, winner=10, en_p1=en_p2=0; start edge: scores 0/0, winner 00, SERVE.
REQ-037 start held high for 20 cycles in IDLE: exactly one transition; rst_n low mid-SERVE at count 5: IDLE, counter 0.
REQ-038 Miss pulses injected in SERVE and POINT, and start edges in PLAY: no state or score change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game controller: FSM state codes, winner codes
// and a saturating score increment.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
    if (score < limit) begin
      sat_inc = score + 4'd1;
    end else begin
      sat_inc = score;
    end
  endfunction

endpackage

// File: rtl/game_ctrl_tick_timer.sv
// Tick-pulse counter shared by the SERVE and POINT phases; done flags the
// tick pulse that completes the programmed count.
module tick_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       tick,
  input  logic [7:0] last,
  output logic [7:0] count,
  output logic       done
);

  logic [7:0] count_r;

  // Counter: load wins over tick so a phase always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= 8'd0;
    end else if (tick) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign done  = tick & (count_r == last);

endmodule

// File: rtl/game_ctrl.sv
// Match sequencer for a two-player paddle game: serve countdown, rally,
// point display and match-over handling with saturating scores.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 8,
  parameter int POINT_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic       en_p1,
  output logic       en_p2,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [3:0] WIN_L      = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_TICKS - 1);

  game_state_e state_r;
  logic [3:0]  score_p1_r;
  logic [3:0]  score_p2_r;
  logic [1:0]  winner_r;
  logic        serve_dir_r;
  logic        start_q_r;
  logic        start_edge_s;
  logic        timed_s;
  logic        load_s;
  logic        done_s;
  logic [7:0]  last_s;
  logic [7:0]  timer_count_unused_s;

  assign start_edge_s = start & ~start_q_r;
  assign timed_s      = (state_r == ST_SERVE) || (state_r == ST_POINT);
  assign last_s       = (state_r == ST_POINT) ? POINT_LAST : SERVE_LAST;
  // Timer is held clear outside the timed phases and cleared as a phase ends.
  assign load_s       = ~timed_s | done_s;

  tick_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .tick  (tick),
    .last  (last_s),
    .count (timer_count_unused_s),
    .done  (done_s)
  );

  // Start button history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q_r <= 1'b0;
    end else begin
      start_q_r <= start;
    end
  end

  // Match FSM with score, winner and serve-direction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      score_p1_r  <= 4'd0;
      score_p2_r  <= 4'd0;
      winner_r    <= WINNER_NONE;
      serve_dir_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OVER: begin
          if (start_edge_s) begin
            score_p1_r <= 4'd0;
            score_p2_r <= 4'd0;
            winner_r   <= WINNER_NONE;
            state_r    <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (done_s) begin
            state_r <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (miss_p1 && miss_p2) begin
            state_r <= ST_POINT;
          end else if (miss_p1) begin
            score_p2_r  <= sat_inc(score_p2_r, WIN_L);
            serve_dir_r <= 1'b0;
            state_r     <= ST_POINT;
          end else if (miss_p2) begin
            score_p1_r  <= sat_inc(score_p1_r, WIN_L);
            serve_dir_r <= 1'b1;
            state_r     <= ST_POINT;
          end
        end
        ST_POINT: begin
          if (done_s) begin
            if (score_p1_r == WIN_L) begin
              winner_r <= WINNER_P1;
              state_r  <= ST_OVER;
            end else if (score_p2_r == WIN_L) begin
              winner_r <= WINNER_P2;
              state_r  <= ST_OVER;
            end else begin
              state_r  <= ST_SERVE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Paddle and ball controls decoded from the registered state only.
  always_comb begin
    en_p1      = 1'b0;
    ball_reset = 1'b1;
    ball_run   = 1'b0;
    case (state_r)
      ST_SERVE, ST_POINT: begin
        en_p1      = 1'b1;
        ball_reset = 1'b1;
        ball_run   = 1'b0;
      end
      ST_PLAY: begin
        en_p1      = 1'b1;
        ball_reset = 1'b0;
        ball_run   = 1'b1;
      end
      default: begin
        en_p1      = 1'b0;
        ball_reset = 1'b1;
        ball_run   = 1'b0;
      end
    endcase
  end

  assign en_p2     = en_p1;
  assign serve_dir = serve_dir_r;
  assign score_p1  = score_p1_r;
  assign score_p2  = score_p2_r;
  assign winner    = winner_r;
  assign state     = state_r;

endmodule
